ibuf_serial_rx: RTL and testbench

- Receive-side counterpart of the O_BUFT pad transmitter testcase: takes a single-wire serial line from a pad, deserializes it and presents parallel bytes.
- The pad enters through an internal I_BUF (EN tied 1'b1), then a 2-flop synchronizer and optional polarity inversion, undoing the inverted-data driver at the far end.
- Frames are start bit, DATA_W data bits LSB first, one stop bit, oversampled at DIV clocks per bit.
- Output is a valid/ready byte interface with frame-error and overrun flags; sits at the chip top between the pad and user logic.

---
 rtl/ibuf_serial_rx.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ibuf_serial_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_serial_rx.sv
// ---------------------------------------------------------------------------
// ibuf_serial_rx
//
// Purpose:
//   Receive side of the pad serial link. The raw pad passes through an
//   always-enabled input buffer, then a two-flop synchronizer with optional
//   polarity correction. This undoes the inverted-data driver at the far end.
//   Frames are one start bit, DATA_W data bits LSB first and one stop bit.
//   The line is oversampled at DIV clocks per bit. Completed words leave on
//   a valid/ready interface. Framing errors and overruns are reported as
//   one-cycle pulses.
//
// Parameters:
//   DIV     clocks per bit period (even, >= 4)
//   DATA_W  data bits per frame (5..9)
//   INVERT  1 = pad carries inverted data (logical line = ~pad)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   data_i       raw serial pad input
//   en_i         receiver enable, 0 parks the FSM in IDLE
//   ready_i      consumer accepts data_o when valid_o & ready_i
//   data_o       received word
//   valid_o      data_o holds an unconsumed word
//   frame_err_o  one-cycle pulse, stop bit sampled low
//   overrun_o    one-cycle pulse, word completed while previous unconsumed
//   busy_o       FSM is not in IDLE
// ---------------------------------------------------------------------------

// Input pad buffer. It is modelled behaviourally so the receiver stays
// self-contained. The enable is tied high by the receiver.
module I_BUF (
  input  logic I,
  input  logic EN,
  output logic O
);

  assign O = EN ? I : 1'b0;

endmodule

module ibuf_serial_rx #(
  parameter int DIV    = 16,
  parameter int DATA_W = 8,
  parameter bit INVERT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_i,
  input  logic              en_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_W + 1);

  // The start bit is checked half a bit after the falling edge. Every later
  // sample falls a full bit period after the previous one, which keeps all
  // samples centred in their bit cells.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_lineD;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_frameErr;
  logic                r_overrun;
  logic                r_busy;

  logic                w_pad;
  logic                w_line;
  logic                w_fallEdge;
  logic                w_accept;

  state_t              w_stateNext;
  logic [CNT_W-1:0]    w_cntNext;
  logic [IDX_W-1:0]    w_idxNext;
  logic [DATA_W-1:0]   w_shiftNext;
  logic                w_wordDone;
  logic                w_stopBad;

  logic [DATA_W-1:0]   w_dataNext;
  logic                w_validNext;
  logic                w_frameErrNext;
  logic                w_overrunNext;

  I_BUF u_ibuf (
    .I  (data_i),
    .EN (1'b1),
    .O  (w_pad)
  );

  // Polarity is corrected ahead of the synchronizer. Both flops therefore
  // hold the logical line level and can reset to the logical idle level (1),
  // whatever the pad polarity. Latency is the same as correcting afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_lineD <= 1'b1;
    end else begin
      r_sync1 <= w_pad ^ INVERT;
      r_sync2 <= r_sync1;
      r_lineD <= r_sync2;
    end
  end

  assign w_line     = r_sync2;
  assign w_fallEdge = r_lineD & ~w_line;

  // Frame sequencing. The counter tracks clocks within the current bit. The
  // index counts data bits already shifted in. Data enters at the MSB, so
  // after DATA_W samples the first-received bit sits in the LSB. A low
  // enable overrides everything and drops any partial frame silently.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_idxNext   = r_idx;
    w_shiftNext = r_shift;
    w_wordDone  = 1'b0;
    w_stopBad   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cntNext = '0;
        w_idxNext = '0;
        if (w_fallEdge) begin
          w_stateNext = S_START;
        end
      end

      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cntNext   = '0;
          w_idxNext   = '0;
          w_stateNext = w_line ? S_IDLE : S_DATA;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cntNext   = '0;
          w_shiftNext = {w_line, r_shift[DATA_W-1:1]};
          w_idxNext   = r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            w_stateNext = S_STOP;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cntNext   = '0;
          w_idxNext   = '0;
          w_stateNext = S_IDLE;
          if (w_line) begin
            w_wordDone = 1'b1;
          end else begin
            w_stopBad = 1'b1;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = S_IDLE;
        w_cntNext   = '0;
        w_idxNext   = '0;
      end
    endcase

    if (!en_i) begin
      w_stateNext = S_IDLE;
      w_cntNext   = '0;
      w_idxNext   = '0;
      w_wordDone  = 1'b0;
      w_stopBad   = 1'b0;
    end
  end

  // FSM state, bit timing and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_idx   <= w_idxNext;
      r_shift <= w_shiftNext;
      r_busy  <= (w_stateNext != S_IDLE);
    end
  end

  // Output holding register and handshake. A consumer accept in the same
  // cycle as a completed word frees the slot, so the new word replaces the
  // old one without an overrun. Otherwise the new word is dropped and the
  // unconsumed word stays put. The stop sample does not touch the shift
  // register, so r_shift already holds the finished word here.
  always_comb begin
    w_accept       = r_valid & ready_i;
    w_dataNext     = r_data;
    w_validNext    = r_valid & ~w_accept;
    w_frameErrNext = w_stopBad;
    w_overrunNext  = 1'b0;

    if (w_wordDone) begin
      if (!r_valid || w_accept) begin
        w_dataNext  = r_shift;
        w_validNext = 1'b1;
      end else begin
        w_overrunNext = 1'b1;
      end
    end
  end

  // Registered outputs. The error flags are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_data     <= w_dataNext;
      r_valid    <= w_validNext;
      r_frameErr <= w_frameErrNext;
      r_overrun  <= w_overrunNext;
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frameErr;
  assign overrun_o   = r_overrun;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_ibuf_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_ibuf_serial_rx
//
// Purpose:
//   Self-checking bench for ibuf_serial_rx with INVERT=1, DIV=4, DATA_W=8.
//   Words expected on the output are queued when their frame is driven.
//   They are popped and compared whenever the consumer accepts a word.
//   Error pulses and valid cycles are counted and checked per scenario.
// ---------------------------------------------------------------------------
module tb_ibuf_serial_rx;

  localparam int DIV    = 4;
  localparam int DATA_W = 8;
  localparam bit INVERT = 1'b1;

  logic              clk = 1'b0;
  logic              rst;
  logic              dataI;
  logic              enI;
  logic              readyI;
  logic [DATA_W-1:0] dataO;
  logic              validO;
  logic              frameErrO;
  logic              overrunO;
  logic              busyO;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] expQ[$];
  int frameErrCount = 0;
  int overrunCount  = 0;
  int validCycles   = 0;
  bit busySeen      = 1'b0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              stopBit;
    logic              expDeliver;
    int                expFrameErr;
  } vec_t;

  vec_t vectors[7];

  always #5 clk = ~clk;

  ibuf_serial_rx #(
    .DIV    (DIV),
    .DATA_W (DATA_W),
    .INVERT (INVERT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (dataI),
    .en_i        (enI),
    .ready_i     (readyI),
    .data_o      (dataO),
    .valid_o     (validO),
    .frame_err_o (frameErrO),
    .overrun_o   (overrunO),
    .busy_o      (busyO)
  );

  // Output monitor on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frameErrO === 1'b1) frameErrCount++;
      if (overrunO === 1'b1) overrunCount++;
      if (validO === 1'b1) validCycles++;
      if (busyO === 1'b1) busySeen = 1'b1;
      if (validO === 1'b1 && readyI === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: actual data_o=%02h, required no word", dataO);
        end else begin
          logic [DATA_W-1:0] expWord;
          expWord = expQ.pop_front();
          if (dataO !== expWord) begin
            errors++;
            $display("[TB] FAIL accepted_word: actual data_o=%02h, required %02h", dataO, expWord);
          end
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bit period of a logical level onto the pad.
  task automatic driveBit(input logic b);
    dataI = INVERT ? ~b : b;
    repeat (DIV) tick();
  endtask

  task automatic driveIdle(input int n);
    dataI = INVERT ? 1'b0 : 1'b1;
    repeat (n) tick();
  endtask

  // Drive a full frame. When abortBit names a data bit, the receiver is
  // disabled for that bit period and re-enabled afterwards.
  task automatic sendFrame(input logic [DATA_W-1:0] data, input logic stopBit,
                           input int abortBit);
    driveBit(1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == abortBit) begin
        enI   = 1'b0;
        dataI = INVERT ? ~data[i] : data[i];
        repeat (DIV / 2) tick();
        checkOutput("busy_while_disabled", {31'd0, busyO}, 32'd0);
        repeat (DIV / 2) tick();
        enI = 1'b1;
      end else begin
        driveBit(data[i]);
      end
    end
    driveBit(stopBit);
  endtask

  task automatic applyStimulus(input vec_t v);
    int fe0;
    int ov0;
    int vc0;
    fe0 = frameErrCount;
    ov0 = overrunCount;
    vc0 = validCycles;
    if (v.expDeliver) expQ.push_back(v.data);
    sendFrame(v.data, v.stopBit, -1);
    driveIdle(3 * DIV);
    checkOutput($sformatf("frame_err_%02h", v.data), frameErrCount - fe0, v.expFrameErr);
    checkOutput($sformatf("overrun_%02h", v.data), overrunCount - ov0, 32'd0);
    checkOutput($sformatf("valid_cycles_%02h", v.data), validCycles - vc0,
                v.expDeliver ? 32'd1 : 32'd0);
    checkOutput($sformatf("queue_drained_%02h", v.data), expQ.size(), 32'd0);
  endtask

  initial begin
    int fe0;
    int ov0;
    int vc0;

    vectors[0] = '{8'hA5, 1'b1, 1'b1, 0};
    vectors[1] = '{8'h55, 1'b0, 1'b0, 1};
    vectors[2] = '{8'h12, 1'b1, 1'b1, 0};
    vectors[3] = '{8'h00, 1'b1, 1'b1, 0};
    vectors[4] = '{8'hFF, 1'b1, 1'b1, 0};
    vectors[5] = '{8'h80, 1'b1, 1'b1, 0};
    vectors[6] = '{8'h01, 1'b1, 1'b1, 0};

    rst    = 1'b1;
    dataI  = INVERT ? 1'b0 : 1'b1;
    enI    = 1'b1;
    readyI = 1'b0;
    #2;
    checkOutput("reset_valid", {31'd0, validO}, 32'd0);
    checkOutput("reset_data", {24'd0, dataO}, 32'd0);
    checkOutput("reset_busy", {31'd0, busyO}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frameErrO}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrunO}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    driveIdle(2 * DIV);

    // Single frames, consumer always ready.
    readyI = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i]);
    end

    // Back-to-back frames with consumer stalled: second word overruns.
    $display("[TB] overrun sequence");
    readyI = 1'b0;
    fe0 = frameErrCount;
    ov0 = overrunCount;
    expQ.push_back(8'h3C);
    sendFrame(8'h3C, 1'b1, -1);
    sendFrame(8'hC3, 1'b1, -1);
    driveIdle(3 * DIV);
    checkOutput("overrun_pulses", overrunCount - ov0, 32'd1);
    checkOutput("overrun_frame_err", frameErrCount - fe0, 32'd0);
    checkOutput("overrun_held_valid", {31'd0, validO}, 32'd1);
    checkOutput("overrun_held_data", {24'd0, dataO}, 32'h3C);
    readyI = 1'b1;
    tick();
    checkOutput("overrun_valid_drop", {31'd0, validO}, 32'd0);
    checkOutput("overrun_queue_drained", expQ.size(), 32'd0);

    // One-clock logical-low glitch on an idle line must abort in START.
    $display("[TB] glitch sequence");
    fe0 = frameErrCount;
    vc0 = validCycles;
    busySeen = 1'b0;
    dataI = INVERT ? 1'b1 : 1'b0;
    tick();
    driveIdle(3 * DIV);
    checkOutput("glitch_busy_seen", {31'd0, busySeen}, 32'd1);
    checkOutput("glitch_busy_end", {31'd0, busyO}, 32'd0);
    checkOutput("glitch_valid_cycles", validCycles - vc0, 32'd0);
    checkOutput("glitch_frame_err", frameErrCount - fe0, 32'd0);

    // Receiver disabled mid-frame, then a normal frame.
    $display("[TB] enable-abort sequence");
    fe0 = frameErrCount;
    ov0 = overrunCount;
    vc0 = validCycles;
    sendFrame(8'hFF, 1'b1, 4);
    driveIdle(3 * DIV);
    expQ.push_back(8'h81);
    sendFrame(8'h81, 1'b1, -1);
    driveIdle(3 * DIV);
    checkOutput("abort_valid_cycles", validCycles - vc0, 32'd1);
    checkOutput("abort_frame_err", frameErrCount - fe0, 32'd0);
    checkOutput("abort_overrun", overrunCount - ov0, 32'd0);
    checkOutput("abort_queue_drained", expQ.size(), 32'd0);

    // Accept and new-word completion land in the same cycle.
    $display("[TB] simultaneous accept sequence");
    readyI = 1'b0;
    ov0 = overrunCount;
    expQ.push_back(8'h01);
    sendFrame(8'h01, 1'b1, -1);
    driveIdle(3 * DIV);
    checkOutput("simul_first_valid", {31'd0, validO}, 32'd1);
    checkOutput("simul_first_data", {24'd0, dataO}, 32'h01);
    expQ.push_back(8'h02);
    sendFrame(8'h02, 1'b1, -1);
    readyI = 1'b1;
    tick();
    checkOutput("simul_valid_stays", {31'd0, validO}, 32'd1);
    checkOutput("simul_new_data", {24'd0, dataO}, 32'h02);
    driveIdle(3 * DIV);
    checkOutput("simul_overrun", overrunCount - ov0, 32'd0);
    checkOutput("simul_queue_drained", expQ.size(), 32'd0);

    // Async reset mid-frame with a pending word held.
    $display("[TB] reset mid-frame sequence");
    readyI = 1'b0;
    sendFrame(8'h5A, 1'b1, -1);
    driveIdle(3 * DIV);
    checkOutput("pre_reset_valid", {31'd0, validO}, 32'd1);
    checkOutput("pre_reset_data", {24'd0, dataO}, 32'h5A);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    checkOutput("pre_reset_busy", {31'd0, busyO}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_valid", {31'd0, validO}, 32'd0);
    checkOutput("midreset_data", {24'd0, dataO}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busyO}, 32'd0);
    checkOutput("midreset_frame_err", {31'd0, frameErrO}, 32'd0);
    checkOutput("midreset_overrun", {31'd0, overrunO}, 32'd0);
    dataI = INVERT ? 1'b0 : 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    driveIdle(2 * DIV);

    // Receiver works normally after the reset.
    readyI = 1'b1;
    applyStimulus(vectors[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
